// File: rtl/bus_periph_responder.sv
// Bus peripheral responder: CSR bank, external pins, change interrupt,
// and a halting req/ack bridge to a slow backend on register slot 5.
module bus_periph_responder #(
    parameter int unsigned                ADDR_WIDTH     = 32,
    parameter int unsigned                DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0]      BASE_ADDR      = ADDR_WIDTH'(32'h0000_9000),
    parameter int unsigned                TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0]      TIMEOUT_DATA   = DATA_WIDTH'(32'hDEAD_BEEF)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [ADDR_WIDTH-1:0] address_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  we_i,
    input  logic [3:0]            we_ram_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  halt_o,
    output logic                  irq_o,
    input  logic [DATA_WIDTH-1:0] external_data_i,
    output logic [DATA_WIDTH-1:0] external_data_o,
    output logic                  slow_req_o,
    output logic                  slow_we_o,
    output logic [DATA_WIDTH-1:0] slow_wdata_o,
    input  logic [DATA_WIDTH-1:0] slow_rdata_i,
    input  logic                  slow_ack_i
);

    localparam int unsigned IDX_W = 3;
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_EXTOUT = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_EXTIN  = IDX_W'(3);
    localparam logic [IDX_W-1:0] IDX_CHGCNT = IDX_W'(4);
    localparam logic [IDX_W-1:0] IDX_SLOW   = IDX_W'(5);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;

    state_e                  state_q, state_d;
    logic                    served_q, served_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic                    slow_req_q, slow_req_d;
    logic                    slow_we_q, slow_we_d;
    logic [DATA_WIDTH-1:0]   slow_wdata_q, slow_wdata_d;
    logic [DATA_WIDTH-1:0]   slow_rdata_q, slow_rdata_d;
    logic                    irq_en_q, irq_en_d;
    logic [DATA_WIDTH-1:0]   ext_out_q, ext_out_d;
    logic [DATA_WIDTH-1:0]   ext_in_q;
    logic [DATA_WIDTH-1:0]   chg_cnt_q, chg_cnt_d;
    logic                    chg_pend_q, chg_pend_d;
    logic                    timeout_q, timeout_d;
    logic                    irq_q, irq_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic                    sel_c, slot5_c, wr_c, chg_c, soft_clr_c, timeout_set_c, busy_c;
    logic [IDX_W-1:0]        idx_c;
    logic [3:0]              lanes_c;
    logic [DATA_WIDTH-1:0]   wmask_c;
    logic                    unused_addr_lsb;

    // Address decode and byte-lane write mask (no lanes means full word)
    assign sel_c           = (address_i[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5]);
    assign idx_c           = address_i[4:2];
    assign unused_addr_lsb = ^address_i[1:0];
    assign slot5_c         = sel_c && (idx_c == IDX_SLOW);
    assign wr_c            = sel_c && we_i;
    assign lanes_c         = (we_ram_i == 4'b0000) ? 4'b1111 : we_ram_i;
    assign wmask_c         = {{8{lanes_c[3]}}, {8{lanes_c[2]}}, {8{lanes_c[1]}}, {8{lanes_c[0]}}};
    assign soft_clr_c      = wr_c && (idx_c == IDX_CTRL) && lanes_c[0] && wdata_i[1];
    assign chg_c           = (external_data_i != ext_in_q);
    assign busy_c          = (state_q != S_IDLE);

    // Stall from the first cycle of an unserved slot-5 access; dropped while in reset
    assign halt_o = reset_i && slot5_c && !served_q;

    assign rdata_o         = rdata_q;
    assign irq_o           = irq_q;
    assign external_data_o = ext_out_q;
    assign slow_req_o      = slow_req_q;
    assign slow_we_o       = slow_we_q;
    assign slow_wdata_o    = slow_wdata_q;

    // Slow-backend FSM next state and handshake datapath
    always_comb begin
        state_d       = state_q;
        served_d      = served_q;
        timer_d       = timer_q;
        slow_req_d    = 1'b0;
        slow_we_d     = slow_we_q;
        slow_wdata_d  = slow_wdata_q;
        slow_rdata_d  = slow_rdata_q;
        timeout_set_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (slot5_c && !served_q) begin
                    slow_we_d    = we_i;
                    slow_wdata_d = wdata_i;
                    timer_d      = '0;
                    slow_req_d   = 1'b1;
                    state_d      = S_REQ;
                end
            end
            S_REQ: begin
                timer_d    = timer_q + TMR_W'(1);
                slow_req_d = 1'b1;
                if (slow_ack_i) begin
                    if (!slow_we_q) slow_rdata_d = slow_rdata_i;
                    slow_req_d = 1'b0;
                    served_d   = 1'b1;
                    state_d    = S_DONE;
                end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_set_c = 1'b1;
                    slow_rdata_d  = TIMEOUT_DATA;
                    slow_req_d    = 1'b0;
                    served_d      = 1'b1;
                    state_d       = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (!slot5_c) served_d = 1'b0;
    end

    // Register bank updates; status sets take priority over clears
    always_comb begin
        irq_en_d   = irq_en_q;
        ext_out_d  = ext_out_q;
        chg_cnt_d  = chg_cnt_q;
        chg_pend_d = chg_pend_q;
        timeout_d  = timeout_q;
        if (wr_c && (idx_c == IDX_CTRL) && lanes_c[0]) irq_en_d = wdata_i[0];
        if (wr_c && (idx_c == IDX_EXTOUT)) ext_out_d = (ext_out_q & ~wmask_c) | (wdata_i & wmask_c);
        if (wr_c && (idx_c == IDX_STATUS)) begin
            if (lanes_c[0] && wdata_i[0]) chg_pend_d = 1'b0;
            if (lanes_c[0] && wdata_i[2]) timeout_d  = 1'b0;
        end
        if (soft_clr_c) begin
            chg_cnt_d  = '0;
            chg_pend_d = 1'b0;
            timeout_d  = 1'b0;
        end
        if (chg_c) begin
            chg_cnt_d  = chg_cnt_d + DATA_WIDTH'(1);
            chg_pend_d = 1'b1;
        end
        if (timeout_set_c) timeout_d = 1'b1;
        irq_d = irq_en_d && chg_pend_d;
    end

    // Read mux, zero outside the window
    always_comb begin
        rdata_d = '0;
        if (sel_c) begin
            case (idx_c)
                IDX_CTRL:   rdata_d = {{(DATA_WIDTH-1){1'b0}}, irq_en_q};
                IDX_STATUS: rdata_d = {{(DATA_WIDTH-3){1'b0}}, timeout_q, busy_c, chg_pend_q};
                IDX_EXTOUT: rdata_d = ext_out_q;
                IDX_EXTIN:  rdata_d = ext_in_q;
                IDX_CHGCNT: rdata_d = chg_cnt_q;
                IDX_SLOW:   rdata_d = slow_rdata_q;
                default:    rdata_d = '0;
            endcase
        end
    end

    // State and register storage
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q      <= S_IDLE;
            served_q     <= 1'b0;
            timer_q      <= '0;
            slow_req_q   <= 1'b0;
            slow_we_q    <= 1'b0;
            slow_wdata_q <= '0;
            slow_rdata_q <= '0;
            irq_en_q     <= 1'b0;
            ext_out_q    <= '0;
            ext_in_q     <= '0;
            chg_cnt_q    <= '0;
            chg_pend_q   <= 1'b0;
            timeout_q    <= 1'b0;
            irq_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            served_q     <= served_d;
            timer_q      <= timer_d;
            slow_req_q   <= slow_req_d;
            slow_we_q    <= slow_we_d;
            slow_wdata_q <= slow_wdata_d;
            slow_rdata_q <= slow_rdata_d;
            irq_en_q     <= irq_en_d;
            ext_out_q    <= ext_out_d;
            ext_in_q     <= external_data_i;
            chg_cnt_q    <= chg_cnt_d;
            chg_pend_q   <= chg_pend_d;
            timeout_q    <= timeout_d;
            irq_q        <= irq_d;
            rdata_q      <= rdata_d;
        end
    end

endmodule

// File: tb/tb_bus_periph_responder.sv
// Scenario bench for bus_periph_responder; a second instance with a short
// timeout exercises the slow-access timeout path.
module tb_bus_periph_responder;

    localparam logic [31:0] BASE = 32'h0000_9000;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic [31:0] address_i = '0;
    logic [31:0] wdata_i = '0;
    logic        we_i = 1'b0;
    logic [3:0]  we_ram_i = '0;
    logic [31:0] external_data_i = '0;
    logic [31:0] slow_rdata_i = '0;
    logic        slow_ack_i = 1'b0;
    logic [31:0] rdata_o, external_data_o, slow_wdata_o;
    logic        halt_o, irq_o, slow_req_o, slow_we_o;

    logic [31:0] addr_to = '0;
    logic        ack_to = 1'b0;
    logic [31:0] ext_to = '0;
    logic [31:0] rdata_to, ext_o_to, slow_wdata_to;
    logic        halt_to, irq_to, slow_req_to, slow_we_to;

    int          total = 0;
    int          bad = 0;
    logic [31:0] sb[$];
    logic [31:0] exp_v, rd;

    always #5 clk_i = ~clk_i;

    bus_periph_responder u_dut (
        .clk_i(clk_i), .reset_i(reset_i), .address_i(address_i), .wdata_i(wdata_i),
        .we_i(we_i), .we_ram_i(we_ram_i), .rdata_o(rdata_o), .halt_o(halt_o), .irq_o(irq_o),
        .external_data_i(external_data_i), .external_data_o(external_data_o),
        .slow_req_o(slow_req_o), .slow_we_o(slow_we_o), .slow_wdata_o(slow_wdata_o),
        .slow_rdata_i(slow_rdata_i), .slow_ack_i(slow_ack_i)
    );

    bus_periph_responder #(.TIMEOUT_CYCLES(4)) u_to (
        .clk_i(clk_i), .reset_i(reset_i), .address_i(addr_to), .wdata_i(wdata_i),
        .we_i(we_i), .we_ram_i(we_ram_i), .rdata_o(rdata_to), .halt_o(halt_to), .irq_o(irq_to),
        .external_data_i(ext_to), .external_data_o(ext_o_to),
        .slow_req_o(slow_req_to), .slow_we_o(slow_we_to), .slow_wdata_o(slow_wdata_to),
        .slow_rdata_i(slow_rdata_i), .slow_ack_i(ack_to)
    );

    // All bus tasks start and end 1 time unit after a rising edge
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        address_i = a; wdata_i = d; we_ram_i = be; we_i = 1'b1;
        @(posedge clk_i); #1;
        we_i = 1'b0; we_ram_i = '0; address_i = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        address_i = a; we_i = 1'b0;
        @(posedge clk_i); #1;
        d = rdata_o; address_i = '0;
    endtask

    task automatic write_to(input logic [31:0] a, input logic [31:0] d);
        addr_to = a; address_i = '0; wdata_i = d; we_ram_i = '0; we_i = 1'b1;
        @(posedge clk_i); #1;
        we_i = 1'b0; addr_to = '0;
    endtask

    task automatic read_to(input logic [31:0] a, output logic [31:0] d);
        addr_to = a; we_i = 1'b0;
        @(posedge clk_i); #1;
        d = rdata_to; addr_to = '0;
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        total++; if (rdata_o !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", rdata_o); end
        total++; if (external_data_o !== 32'h0) begin bad++; $display("FAIL rst_ext_out: got %h want 0", external_data_o); end
        total++; if ({irq_o, slow_req_o, halt_o} !== 3'b000) begin bad++; $display("FAIL rst_ctrl_outs: got %b want 000", {irq_o, slow_req_o, halt_o}); end
        #2 reset_i = 1'b1;
        @(posedge clk_i); #1;
        sb.push_back(32'h0);
        bus_read(BASE + 32'h8, rd);
        exp_v = sb.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL rst_read_extout: got %h want %h", rd, exp_v); end
    endtask

    task automatic test_ext_out();
        bus_write(BASE + 32'h8, 32'hFFFF_FFFF, 4'b0000);
        total++; if (external_data_o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL ext_out_full: got %h want ffffffff", external_data_o); end
        bus_write(BASE + 32'h8, 32'h1234_5678, 4'b0011);
        total++; if (external_data_o !== 32'hFFFF_5678) begin bad++; $display("FAIL ext_out_lanes: got %h want ffff5678", external_data_o); end
        sb.push_back(32'hFFFF_5678);
        bus_read(BASE + 32'h8, rd);
        exp_v = sb.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL ext_out_readback: got %h want %h", rd, exp_v); end
        sb.push_back(32'hFFFF_5678);
        bus_read(BASE + 32'hA, rd);
        exp_v = sb.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL addr_lsb_ignored: got %h want %h", rd, exp_v); end
        bus_write(BASE + 32'h18, 32'hAAAA_AAAA, 4'b0000);
        bus_write(BASE + 32'h28, 32'h5555_5555, 4'b0000);
        total++; if (external_data_o !== 32'hFFFF_5678) begin bad++; $display("FAIL ext_out_stray_write: got %h want ffff5678", external_data_o); end
        sb.push_back(32'h0);
        bus_read(BASE + 32'h18, rd);
        exp_v = sb.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL slot6_read: got %h want %h", rd, exp_v); end
        sb.push_back(32'h0);
        bus_read(BASE + 32'h28, rd);
        exp_v = sb.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL outside_window_read: got %h want %h", rd, exp_v); end
    endtask

    task automatic test_ext_in();
        bus_write(BASE + 32'h0, 32'h1, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            external_data_i = (i % 2 == 0) ? 32'h0000_00F0 : 32'h0;
            repeat (2) @(posedge clk_i);
            #1;
        end
        repeat (2) @(posedge clk_i);
        #1;
        total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL irq_after_changes: got %b want 1", irq_o); end
        sb.push_back(32'd3);
        bus_read(BASE + 32'h10, rd);
        exp_v = sb.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL chg_cnt_3: got %h want %h", rd, exp_v); end
        sb.push_back(32'h0000_00F0);
        bus_read(BASE + 32'hC, rd);
        exp_v = sb.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL ext_in: got %h want %h", rd, exp_v); end
        sb.push_back(32'h1);
        bus_read(BASE + 32'h4, rd);
        exp_v = sb.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL status_pend: got %h want %h", rd, exp_v); end
        bus_write(BASE + 32'h4, 32'h1, 4'b0000);
        total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL irq_w1c: got %b want 0", irq_o); end
        // W1C and a new change in the same cycle: the set must win
        address_i = BASE + 32'h4; wdata_i = 32'h1; we_i = 1'b1;
        external_data_i = 32'h0;
        @(posedge clk_i); #1;
        we_i = 1'b0; address_i = '0;
        total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL irq_set_wins: got %b want 1", irq_o); end
        sb.push_back(32'd4);
        bus_read(BASE + 32'h10, rd);
        exp_v = sb.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL chg_cnt_4: got %h want %h", rd, exp_v); end
        bus_write(BASE + 32'h0, 32'h3, 4'b0000);
        total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL irq_soft_clr: got %b want 0", irq_o); end
        sb.push_back(32'h0);
        bus_read(BASE + 32'h10, rd);
        exp_v = sb.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL chg_cnt_soft_clr: got %h want %h", rd, exp_v); end
        sb.push_back(32'h1);
        bus_read(BASE + 32'h0, rd);
        exp_v = sb.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL ctrl_readback: got %h want %h", rd, exp_v); end
        bus_write(BASE + 32'h0, 32'h0, 4'b0000);
    endtask

    task automatic test_slow_read();
        int halt_cnt = 0;
        int req_cnt = 0;
        slow_rdata_i = 32'hCAFE_0001;
        address_i = BASE + 32'h14; we_i = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (halt_o) halt_cnt++;
            if (slow_req_o) begin
                req_cnt++;
                if (req_cnt == 5) begin
                    slow_ack_i = 1'b1;
                    sb.push_back(32'hCAFE_0001);
                end
            end
            if (c == 7) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL slow_rdata: got no ack issued want cafe0001");
                end else begin
                    exp_v = sb.pop_front();
                    if (rdata_o !== exp_v) begin bad++; $display("FAIL slow_rdata: got %h want %h", rdata_o, exp_v); end
                end
            end
            @(posedge clk_i); #1;
            slow_ack_i = 1'b0;
        end
        address_i = '0;
        total++; if (halt_cnt != 6) begin bad++; $display("FAIL slow_halt_cycles: got %0d want 6", halt_cnt); end
        total++; if (req_cnt != 5) begin bad++; $display("FAIL slow_req_cycles: got %0d want 5", req_cnt); end
        sb.push_back(32'h0);
        bus_read(BASE + 32'h4, rd);
        exp_v = sb.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL status_after_slow: got %h want %h", rd, exp_v); end
    endtask

    task automatic test_slow_timeout();
        logic        p_we [3]  = '{1'b1, 1'b0, 1'b0};
        int          p_ack[3]  = '{0, 0, 4};
        logic [31:0] p_rd [3]  = '{32'h0, 32'hDEAD_BEEF, 32'h1357_9BDF};
        logic [31:0] p_st [3]  = '{32'h4, 32'h4, 32'h0};
        for (int p = 0; p < 3; p++) begin
            int halt_cnt = 0;
            int req_cnt = 0;
            slow_rdata_i = 32'h1357_9BDF;
            addr_to = BASE + 32'h14; address_i = '0;
            we_i = p_we[p]; wdata_i = 32'hA5A5_0F0F; we_ram_i = 4'b0001;
            if (!p_we[p]) sb.push_back(p_rd[p]);
            for (int c = 0; c < 10; c++) begin
                #1;
                if (halt_to) halt_cnt++;
                if (slow_req_to) begin
                    req_cnt++;
                    if (req_cnt == p_ack[p]) ack_to = 1'b1;
                end
                if (c == 1 && p_we[p]) begin
                    total++; if ({slow_we_to, slow_wdata_to} !== {1'b1, 32'hA5A5_0F0F}) begin
                        bad++; $display("FAIL slow_wr_latch: got %b/%h want 1/a5a50f0f", slow_we_to, slow_wdata_to);
                    end
                end
                if (c == 6 && !p_we[p]) begin
                    exp_v = sb.pop_front();
                    total++; if (rdata_to !== exp_v) begin bad++; $display("FAIL slow_to_rdata_p%0d: got %h want %h", p, rdata_to, exp_v); end
                end
                @(posedge clk_i); #1;
                we_i = 1'b0; we_ram_i = '0; ack_to = 1'b0;
            end
            total++; if (halt_cnt != 5) begin bad++; $display("FAIL slow_to_halt_p%0d: got %0d want 5", p, halt_cnt); end
            total++; if (req_cnt != 4) begin bad++; $display("FAIL slow_to_req_p%0d: got %0d want 4", p, req_cnt); end
            sb.push_back(p_st[p]);
            read_to(BASE + 32'h4, rd);
            exp_v = sb.pop_front();
            total++; if (rd !== exp_v) begin bad++; $display("FAIL slow_to_status_p%0d: got %h want %h", p, rd, exp_v); end
            write_to(BASE + 32'h4, 32'h4);
            sb.push_back(32'h0);
            read_to(BASE + 32'h4, rd);
            exp_v = sb.pop_front();
            total++; if (rd !== exp_v) begin bad++; $display("FAIL timeout_w1c_p%0d: got %h want %h", p, rd, exp_v); end
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        address_i = BASE + 32'h14; we_i = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk_i); #1;
            if (slow_req_o) seen = 1'b1;
        end
        total++; if (!seen) begin bad++; $display("FAIL mid_req_start: got no slow_req_o want 1 within 10 cycles"); end
        reset_i = 1'b0;
        #1;
        total++; if ({slow_req_o, halt_o} !== 2'b00) begin bad++; $display("FAIL mid_reset_outs: got %b want 00", {slow_req_o, halt_o}); end
        address_i = '0;
        @(posedge clk_i); #3;
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        slow_ack_i = 1'b1;
        @(posedge clk_i); #1;
        slow_ack_i = 1'b0;
        total++; if ({slow_req_o, halt_o} !== 2'b00) begin bad++; $display("FAIL orphan_ack_outs: got %b want 00", {slow_req_o, halt_o}); end
        sb.push_back(32'h0);
        bus_read(BASE + 32'h4, rd);
        exp_v = sb.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL orphan_ack_status: got %h want %h", rd, exp_v); end
        sb.push_back(32'h0);
        bus_read(BASE + 32'h8, rd);
        exp_v = sb.pop_front();
        total++; if (rd !== exp_v) begin bad++; $display("FAIL mid_reset_extout: got %h want %h", rd, exp_v); end
    endtask

    initial begin
        test_reset();
        test_ext_out();
        test_ext_in();
        test_slow_read();
        test_slow_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
